// File: rtl/if_stage_hs_if.sv
// rtl/if_stage_hs_if.sv - fetch-stage bundle: ID-side handshake plus class-SRAM instruction port
interface if_stage_hs_if #(
  parameter int PC_W   = 32,
  parameter int INST_W = 32
);
  logic                     id_allowin;
  logic [PC_W:0]            br_bus;
  logic                     if_to_id_valid;
  logic [INST_W+PC_W-1:0]   if_to_id_bus;
  logic                     inst_sram_req;
  logic                     inst_sram_wr;
  logic [1:0]               inst_sram_size;
  logic [3:0]               inst_sram_wstrb;
  logic [PC_W-1:0]          inst_sram_addr;
  logic [31:0]              inst_sram_wdata;
  logic                     inst_sram_addr_ok;
  logic                     inst_sram_data_ok;
  logic [INST_W-1:0]        inst_sram_rdata;

  modport master (
    input  id_allowin, br_bus, inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
    output if_to_id_valid, if_to_id_bus, inst_sram_req, inst_sram_wr, inst_sram_size,
           inst_sram_wstrb, inst_sram_addr, inst_sram_wdata
  );

  modport slave (
    output id_allowin, br_bus, inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
    input  if_to_id_valid, if_to_id_bus, inst_sram_req, inst_sram_wr, inst_sram_size,
           inst_sram_wstrb, inst_sram_addr, inst_sram_wdata
  );
endinterface

// File: rtl/if_stage_hs.sv
// rtl/if_stage_hs.sv - instruction fetch with one outstanding SRAM request and a small {inst, pc} buffer
// Redirects flush the buffer and mark an in-flight response for discard.
module if_stage_hs #(
  parameter int              PC_W      = 32,
  parameter logic [PC_W-1:0] RESET_PC  = 32'h1c000000,
  parameter int              INST_W    = 32,
  parameter int              BUF_DEPTH = 2
) (
  input  logic          clk,
  input  logic          reset,
  if_stage_hs_if.master bus
);
  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [PC_W-1:0]        fetch_pc;
  logic [PC_W-1:0]        pending_pc;
  logic                   pending;
  logic                   cancel;
  logic [CNT_W-1:0]       count;
  logic [PTR_W-1:0]       rd_ptr;
  logic [PTR_W-1:0]       wr_ptr;
  logic [INST_W+PC_W-1:0] buf_mem [BUF_DEPTH];

  logic            br_taken;
  logic [PC_W-1:0] br_target;
  logic            full;
  logic            addr_hs;
  logic            data_hs;
  logic            push;
  logic            pop;

  assign br_taken  = bus.br_bus[PC_W];
  assign br_target = bus.br_bus[PC_W-1:0];
  assign full      = (count == CNT_W'(BUF_DEPTH));

  assign bus.inst_sram_req   = ~reset & ~pending & (count < CNT_W'(BUF_DEPTH)) & ~br_taken;
  assign bus.inst_sram_addr  = fetch_pc;
  assign bus.inst_sram_wr    = 1'b0;
  assign bus.inst_sram_size  = 2'd2;
  assign bus.inst_sram_wstrb = 4'd0;
  assign bus.inst_sram_wdata = 32'd0;

  assign addr_hs = bus.inst_sram_req & bus.inst_sram_addr_ok;
  assign data_hs = bus.inst_sram_data_ok & pending;
  // A response returning during a redirect is stale even when cancel is not yet set.
  assign push    = data_hs & ~cancel & ~br_taken;

  assign bus.if_to_id_valid = (count != '0) & ~br_taken;
  assign bus.if_to_id_bus   = buf_mem[rd_ptr];
  assign pop                = bus.if_to_id_valid & bus.id_allowin;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc   <= RESET_PC;
      pending_pc <= '0;
      pending    <= 1'b0;
      cancel     <= 1'b0;
      count      <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
    end else begin
      if (addr_hs) begin
        pending    <= 1'b1;
        pending_pc <= fetch_pc;
        fetch_pc   <= fetch_pc + PC_W'(4);
      end
      if (data_hs) begin
        pending <= 1'b0;
        cancel  <= 1'b0;
      end
      if (br_taken) begin
        fetch_pc <= br_target;
        count    <= '0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        if (pending && !bus.inst_sram_data_ok) cancel <= 1'b1;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        if (push && !pop)      count <= count + CNT_W'(1);
        else if (pop && !push) count <= count - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) buf_mem[wr_ptr] <= {bus.inst_sram_rdata, pending_pc};
  end

  // Issue is gated on free space with one request in flight, so a response always fits.
  assert property (@(posedge clk) disable iff (reset) !(push && full));
endmodule
